// File: rtl/wasca_hex_disp_pkg.sv
// Shared constants for the Wasca seven-segment display controller:
// register map, hex font and digit limit.
package wasca_hex_disp_pkg;

   localparam int MAX_DIGITS = 8;

   localparam logic [2:0] ADDR_VALUE     = 3'd0;
   localparam logic [2:0] ADDR_DOT       = 3'd1;
   localparam logic [2:0] ADDR_DOT_SET   = 3'd2;
   localparam logic [2:0] ADDR_DOT_CLR   = 3'd3;
   localparam logic [2:0] ADDR_BLANK     = 3'd4;
   localparam logic [2:0] ADDR_BLINK     = 3'd5;
   localparam logic [2:0] ADDR_BLINK_DIV = 3'd6;
   localparam logic [2:0] ADDR_STATUS    = 3'd7;

   // Active-high {g,f,e,d,c,b,a}
   localparam logic [6:0] FONT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/wasca_hex_seg_dec.sv
// One digit of hex-to-segment decode; output is active-low {dp,g..a}.
module wasca_hex_seg_dec
   import wasca_hex_disp_pkg::*;
(
   input  logic [3:0] value,
   input  logic       dot,
   input  logic       off,
   output logic [7:0] seg_n
);

   assign seg_n = off ? 8'hFF : ~{dot, FONT[value]};

endmodule

// File: rtl/wasca_hex_disp.sv
// Avalon-MM seven-segment controller, registered active-low outputs.
// Define WASCA_HEX_DISP_BLINK_EN to build the blink prescaler and its registers.
module wasca_hex_disp
   import wasca_hex_disp_pkg::*;
#(
   parameter int NUM_DIGITS    = 6,
   parameter int BLINK_DIV_W   = 26,
   parameter int BLINK_DIV_RST = 25000000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [2:0]              address,
   input  logic                    chipselect,
   input  logic                    write_n,
   input  logic [31:0]             writedata,
   output logic [31:0]             readdata,
   output logic [8*NUM_DIGITS-1:0] seg_n
);

   localparam int VW = 4 * NUM_DIGITS;

   logic                    w_wr;
   logic                    w_unused_wd;
   logic [VW-1:0]           r_value;
   logic [NUM_DIGITS-1:0]   r_dot;
   logic [NUM_DIGITS-1:0]   r_blank;
   logic [NUM_DIGITS-1:0]   w_off;
   logic [8*NUM_DIGITS-1:0] w_seg_n;
   logic [8*NUM_DIGITS-1:0] r_seg_n;

   assign w_wr        = chipselect & ~write_n;
   assign w_unused_wd = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_value <= '0;
         r_dot   <= '0;
         r_blank <= '0;
      end else if (w_wr) begin
         case (address)
            ADDR_VALUE:   r_value <= writedata[VW-1:0];
            ADDR_DOT:     r_dot   <= writedata[NUM_DIGITS-1:0];
            ADDR_DOT_SET: r_dot   <= r_dot | writedata[NUM_DIGITS-1:0];
            ADDR_DOT_CLR: r_dot   <= r_dot & ~writedata[NUM_DIGITS-1:0];
            ADDR_BLANK:   r_blank <= writedata[NUM_DIGITS-1:0];
            default: ;
         endcase
      end
   end

`ifdef WASCA_HEX_DISP_BLINK_EN
   logic [NUM_DIGITS-1:0]  r_blink;
   logic [BLINK_DIV_W-1:0] r_div;
   logic [BLINK_DIV_W-1:0] r_cnt;
   logic                   r_phase;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_blink <= '0;
         r_div   <= BLINK_DIV_W'(BLINK_DIV_RST);
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else begin
         if (w_wr && address == ADDR_BLINK)
            r_blink <= writedata[NUM_DIGITS-1:0];
         // A divider rewrite restarts the blink cycle and overrides a wrap
         if (w_wr && address == ADDR_BLINK_DIV) begin
            r_div   <= writedata[BLINK_DIV_W-1:0];
            r_cnt   <= '0;
            r_phase <= 1'b0;
         end else if (r_div == '0) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
         end else if (r_cnt == r_div) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_cnt   <= r_cnt + 1'b1;
         end
      end
   end

   assign w_off = r_blank | (r_blink & {NUM_DIGITS{r_phase}});
`else
   localparam int UNUSED_BLINK_CFG = BLINK_DIV_W + BLINK_DIV_RST;

   assign w_off = r_blank;
`endif

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_VALUE:     readdata[VW-1:0]         = r_value;
         ADDR_DOT:       readdata[NUM_DIGITS-1:0] = r_dot;
         ADDR_BLANK:     readdata[NUM_DIGITS-1:0] = r_blank;
`ifdef WASCA_HEX_DISP_BLINK_EN
         ADDR_BLINK:     readdata[NUM_DIGITS-1:0] = r_blink;
         ADDR_BLINK_DIV: readdata[BLINK_DIV_W-1:0] = r_div;
         ADDR_STATUS:    readdata[0]               = r_phase;
`endif
         default: ;
      endcase
   end

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      wasca_hex_seg_dec u_dec (
         .value (r_value[4*gi +: 4]),
         .dot   (r_dot[gi]),
         .off   (w_off[gi]),
         .seg_n (w_seg_n[8*gi +: 8])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_seg_n <= '1;
      else
         r_seg_n <= w_seg_n;
   end

   assign seg_n = r_seg_n;

endmodule

// File: doc/wasca_hex_disp.md
# wasca_hex_disp

Parametrised Avalon-MM seven-segment display controller for the Wasca board: up to 8 digits, each with a hex value, a decimal point, blanking and optional blinking. It succeeds the single 6-bit dot output port. It sits on the Nios II data-bus slave fabric and drives the board's HEX displays directly. Segment outputs are registered, active-low and non-multiplexed.

## Interface
Parameters:
- NUM_DIGITS, 6, number of digits driven (1..8).
- BLINK_DIV_W, 26, width of the blink prescaler.
- BLINK_DIV_RST, 25000000, reset value of BLINK_DIV; must fit in BLINK_DIV_W bits.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low; clock clk.
- address  in  3  word register index.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational, zero wait states.
- seg_n  out  8*NUM_DIGITS  per digit [7:0] = {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- Register map, with write = chipselect && !write_n:
  - 0 VALUE: 4 bits per digit, digit i at [4i+3:4i].
  - 1 DOT: [NUM_DIGITS-1:0], read/write.
  - 2 DOT_SET: write-1-to-set into DOT; reads 0.
  - 3 DOT_CLR: write-1-to-clear in DOT; reads 0.
  - 4 BLANK: per-digit mask; 1 turns all segments and the dp off.
  - 5 BLINK: per-digit blink-enable mask.
  - 6 BLINK_DIV: prescaler terminal count.
  - 7 STATUS: bit0 = blink phase; read-only.
- Unused upper bits read 0. Writes to unused bits are ignored.
- Decode: 0..F map to a fixed hex font: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. The font is active-high {g..a} and is inverted at the output.
- Digit i is off when BLANK[i] = 1, or when BLINK[i] = 1 and phase = 1. Otherwise seg_n shows ~{DOT[i], font(VALUE digit i)}.
- Blink prescaler:
  - The counter increments every clk.
  - When counter == BLINK_DIV, the counter goes to 0 and the phase toggles.
  - BLINK_DIV = 0 holds the counter and phase at 0, so blinking digits stay visible.
- A write to BLINK_DIV clears the counter and phase in the same edge. This write takes priority over a coincident wrap.
- Reset values:
  - VALUE, DOT, BLANK, BLINK, counter and phase are 0.
  - BLINK_DIV = BLINK_DIV_RST.
  - seg_n is all 1s (all segments off).

## Timing
- A register write sampled at edge N is visible on readdata after edge N. It reaches seg_n at edge N+1: one output register stage.
- A phase toggle at edge N reaches seg_n at edge N+1.
- Blink period is 2*(BLINK_DIV+1) clk cycles.
- Reset asserted mid-blink forces seg_n to all 1s asynchronously. The counter restarts from 0 on release.
- Only one register is accessed per cycle, so SET/CLR conflicts cannot occur.

## Configuration
- WASCA_HEX_DISP_BLINK_EN defined: the prescaler, BLINK, BLINK_DIV and STATUS are implemented as described.
- Not defined:
  - No counter logic is built.
  - Addresses 5..7 read 0 and writes to them are ignored.
  - Phase is a constant 0, so only BLANK suppresses a digit.

## Structure
- Package wasca_hex_disp_pkg holds:
  - the register address constants (ADDR_VALUE..ADDR_STATUS);
  - the 16-entry 7-bit font constant array;
  - the max-digit constant (8).
- Sub-module wasca_hex_seg_dec: purely combinational; inputs value[3:0], dot, off; output seg_n[7:0]. It is instantiated NUM_DIGITS times via generate.

## Test plan
- Reset, then read all addresses -> seg_n = all 1s; every register reads 0 except BLINK_DIV = 25000000.
- Write VALUE = 0x00000F10 -> after 1 cycle, digit0 = 0xC0, digit1 = 0xF9, digit2 = 0x8E, digits 3..5 = 0xC0.
- Write DOT_SET = 0x05, then DOT_CLR = 0x01 -> DOT reads 0x04; digit2 bit7 = 0; DOT_SET and DOT_CLR read 0.
- Write BLANK = 0x02 with VALUE = 0x10 -> digit1 = 0xFF; digit0 = 0xC0.
- Write BLINK = 0x01 and BLINK_DIV = 3 -> STATUS bit0 toggles every 4 cycles; digit0 alternates 0xFF / 0xC0 with 4-cycle halves; other digits are steady.
- Rewrite BLINK_DIV = 3 while phase = 1 -> phase = 0 next cycle and the count restarts.
- Assert reset_n mid-blink -> all 1s immediately.
- Without the macro, the blink scenario -> addresses 5..7 read 0 and no toggling occurs.
